rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the single-write-port register file. Two requesters share the write port: the in-order pipeline writeback and a long-latency unit (load/mul-div) using a valid/ready handshake. Fixed pipeline priority is bounded by an anti-starvation counter. A per-register busy scoreboard tells decode which registers still await a long-latency result.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 81 ++++++++
 tb/tb_rf_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// Imported by the arbiter top and the busy scoreboard.
package rf_wb_arbiter_pkg;

    localparam int REG_AW         = 5;
    localparam int XLEN           = 32;
    localparam int NREG           = 32;
    localparam int MAX_WAIT_LIMIT = 15;

    // One-hot register mask; x0 never maps to a bit.
    function automatic logic [NREG-1:0] reg_bit(
        input logic [REG_AW-1:0] a
    );
        reg_bit = '0;
        if (a != '0)
            reg_bit[a] = 1'b1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on long-op issue, clear on long writeback.
// Set wins over clear on the same register in the same cycle.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] chk_a1,
    input  logic [REG_AW-1:0] chk_a2,
    output logic              hazard,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    assign set_mask = set_en ? reg_bit(set_addr) : '0;
    assign clr_mask = clr_en ? reg_bit(clr_addr) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

    // No bypass of this cycle's clear: hazard drops the cycle after the write.
    assign hazard = |(busy & (reg_bit(chk_a1) | reg_bit(chk_a2)));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the single-write-port register file: pipeline
// priority bounded by an anti-starvation counter, plus busy scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [REG_AW-1:0] p_addr,
    input  logic [XLEN-1:0]   p_data,
    output logic              p_stall,
    input  logic              l_valid,
    input  logic [REG_AW-1:0] l_addr,
    input  logic [XLEN-1:0]   l_data,
    output logic              l_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_addr,
    input  logic [REG_AW-1:0] chk_a1,
    input  logic [REG_AW-1:0] chk_a2,
    output logic              hazard,
    output logic              rf_wr,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd,
    output logic [NREG-1:0]   busy
);

    // Keep at least one bit so MAX_WAIT = 0 still elaborates.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CW-1:0] wait_cnt;
    logic          force_l;
    logic          gl;
    logic          gp;

    assign force_l = (wait_cnt == CW'(MAX_WAIT));
    assign gl      = ~rst & l_valid & (~p_valid | force_l);
    assign gp      = ~rst & p_valid & ~gl;

    assign l_ready = gl;
    assign p_stall = p_valid & gl;

    always_comb begin
        rf_a3 = '0;
        rf_wd = '0;
        if (gl) begin
            rf_a3 = l_addr;
            rf_wd = l_data;
        end else if (gp) begin
            rf_a3 = p_addr;
            rf_wd = p_data;
        end
    end

    // Writes to x0 complete the handshake but never reach the file.
    assign rf_wr = (gl | gp) & (rf_a3 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (gl | ~l_valid)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + CW'(1);
    end

    rf_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_addr (iss_addr),
        .clr_en   (gl),
        .clr_addr (l_addr),
        .chk_a1   (chk_a1),
        .chk_a2   (chk_a2),
        .hazard   (hazard),
        .busy     (busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: two instances (MAX_WAIT 3 and 0)
// checked against a behavioural model of the grant and busy rules.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pv  [2];
    logic [4:0]  pa  [2];
    logic [31:0] pd  [2];
    logic        lv  [2];
    logic [4:0]  la  [2];
    logic [31:0] ld  [2];
    logic        iv  [2];
    logic [4:0]  ia  [2];
    logic [4:0]  c1  [2];
    logic [4:0]  c2  [2];
    logic        ps  [2];
    logic        lr  [2];
    logic        hz  [2];
    logic        wr  [2];
    logic [4:0]  a3  [2];
    logic [31:0] wd  [2];
    logic [31:0] bz  [2];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .p_valid(pv[0]), .p_addr(pa[0]), .p_data(pd[0]), .p_stall(ps[0]),
        .l_valid(lv[0]), .l_addr(la[0]), .l_data(ld[0]), .l_ready(lr[0]),
        .iss_valid(iv[0]), .iss_addr(ia[0]),
        .chk_a1(c1[0]), .chk_a2(c2[0]), .hazard(hz[0]),
        .rf_wr(wr[0]), .rf_a3(a3[0]), .rf_wd(wd[0]), .busy(bz[0])
    );

    rf_wb_arbiter #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .p_valid(pv[1]), .p_addr(pa[1]), .p_data(pd[1]), .p_stall(ps[1]),
        .l_valid(lv[1]), .l_addr(la[1]), .l_data(ld[1]), .l_ready(lr[1]),
        .iss_valid(iv[1]), .iss_addr(ia[1]),
        .chk_a1(c1[1]), .chk_a2(c2[1]), .hazard(hz[1]),
        .rf_wr(wr[1]), .rf_a3(a3[1]), .rf_wd(wd[1]), .busy(bz[1])
    );

    typedef struct {
        int          inst;
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        lr;
        logic        ps;
        logic        hz;
        logic [31:0] bz;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: losses = cycles the pending long result lost.
    int        mw     [2] = '{3, 0};
    int        losses [2];
    bit [31:0] mbusy  [2];
    bit        hold_l [2];
    bit        hold_p [2];

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h",
                     name, inst, $time, act, exp);
        end
    endtask

    // Compute expectations from the current inputs, then advance one cycle.
    task automatic cycle();
        bit gl [2];
        bit gp [2];
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            bit   lose_limit;
            lose_limit = (losses[i] >= mw[i]);
            gl[i] = !rst && lv[i] && (!pv[i] || lose_limit);
            gp[i] = !rst && pv[i] && !gl[i];
            e.inst = i;
            e.a3   = gl[i] ? la[i] : gp[i] ? pa[i] : 5'd0;
            e.wd   = gl[i] ? ld[i] : gp[i] ? pd[i] : 32'd0;
            e.wr   = (gl[i] || gp[i]) && e.a3 != 0;
            e.lr   = gl[i];
            e.ps   = pv[i] && gl[i];
            e.hz   = (c1[i] != 0 && mbusy[i][c1[i]])
                  || (c2[i] != 0 && mbusy[i][c2[i]]);
            e.bz   = mbusy[i];
            q.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                losses[i] = 0;
                mbusy[i]  = '0;
            end else begin
                if (gl[i])
                    mbusy[i][la[i]] = 1'b0;
                if (iv[i] && ia[i] != 0)
                    mbusy[i][ia[i]] = 1'b1;
                losses[i] = (lv[i] && !gl[i]) ? losses[i] + 1 : 0;
            end
            hold_l[i] = lv[i] && !gl[i] && !rst;
            hold_p[i] = pv[i] && gl[i];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        pv[i] = 0; pa[i] = 0; pd[i] = 0;
        lv[i] = 0; la[i] = 0; ld[i] = 0;
        iv[i] = 0; ia[i] = 0; c1[i] = 0; c2[i] = 0;
    endtask

    task automatic rnd(input int i);
        if (!hold_l[i]) begin
            lv[i] = ($urandom % 3) != 0;
            la[i] = 5'($urandom_range(0, 9));
            ld[i] = $urandom;
        end
        if (!hold_p[i]) begin
            pv[i] = ($urandom % 4) != 0;
            pa[i] = 5'($urandom_range(0, 31));
            pd[i] = $urandom;
        end
        iv[i] = ($urandom % 3) == 0;
        ia[i] = 5'($urandom_range(0, 9));
        c1[i] = 5'($urandom_range(0, 9));
        c2[i] = 5'($urandom_range(0, 9));
    endtask

    always @(negedge clk) begin
        #2;
        while (q.size() > 0) begin
            exp_t e;
            int   k;
            e = q.pop_front();
            k = e.inst;
            chk("rf_wr",   k, 32'(wr[k]), 32'(e.wr));
            chk("rf_a3",   k, 32'(a3[k]), 32'(e.a3));
            chk("rf_wd",   k, wd[k],      e.wd);
            chk("l_ready", k, 32'(lr[k]), 32'(e.lr));
            chk("p_stall", k, 32'(ps[k]), 32'(e.ps));
            chk("hazard",  k, 32'(hz[k]), 32'(e.hz));
            chk("busy",    k, bz[k],      e.bz);
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(i);
            losses[i] = 0; mbusy[i] = '0;
            hold_l[i] = 0; hold_p[i] = 0;
        end
        @(negedge clk);
        lv[0] = 1; la[0] = 5'd3; pv[0] = 1; pa[0] = 5'd4;
        cycle();
        cycle();
        rst = 1'b0;
        idle(0);
        cycle();

        // Pipeline priority until the long unit has lost three times.
        pv[0] = 1; pa[0] = 5'd5; pd[0] = 32'hDEAD_BEEF;
        lv[0] = 1; la[0] = 5'd12; ld[0] = 32'h0000_1234;
        repeat (4) cycle();
        lv[0] = 0;
        cycle();
        idle(0);

        // Busy set, hazard, clear by long write.
        iv[0] = 1; ia[0] = 5'd7;
        cycle();
        iv[0] = 0; c1[0] = 5'd7;
        cycle();
        lv[0] = 1; la[0] = 5'd7; ld[0] = 32'hCAFE_0007;
        cycle();
        lv[0] = 0;
        cycle();
        cycle();

        // Simultaneous set and clear of the same register.
        iv[0] = 1; ia[0] = 5'd9;
        cycle();
        lv[0] = 1; la[0] = 5'd9; ld[0] = 32'h9;
        cycle();
        iv[0] = 0; lv[0] = 0; c1[0] = 5'd9;
        cycle();
        lv[0] = 1;
        cycle();
        lv[0] = 0;
        cycle();

        // x0 handling.
        lv[0] = 1; la[0] = 5'd0; ld[0] = 32'h5555_AAAA;
        cycle();
        lv[0] = 0; iv[0] = 1; ia[0] = 5'd0; c1[0] = 5'd0;
        cycle();
        iv[0] = 0;
        cycle();

        // MAX_WAIT = 0: long always wins against an overlapping pipeline.
        pv[1] = 1; pa[1] = 5'd3; pd[1] = 32'h1111_2222;
        lv[1] = 1; la[1] = 5'd6; ld[1] = 32'h3333_4444;
        repeat (4) cycle();
        idle(1);
        cycle();

        // Asynchronous reset mid-cycle with busy = 0xF0.
        for (int r = 4; r < 8; r++) begin
            iv[0] = 1; ia[0] = 5'(r);
            cycle();
        end
        iv[0] = 0;
        cycle();
        chk("busy_pre_rst", 0, bz[0], 32'h0000_00F0);
        lv[0] = 1; la[0] = 5'd8;
        #3 rst = 1'b1;
        #1;
        chk("busy_async_rst",  0, bz[0],       32'd0);
        chk("rf_wr_async_rst", 0, 32'(wr[0]),  32'd0);
        chk("lrdy_async_rst",  0, 32'(lr[0]),  32'd0);
        for (int i = 0; i < 2; i++) begin
            losses[i] = 0; mbusy[i] = '0;
            hold_l[i] = 0; hold_p[i] = 0;
        end
        @(negedge clk);
        cycle();
        rst = 1'b0;
        idle(0);
        cycle();

        for (int n = 0; n < 600; n++) begin
            rnd(0);
            rnd(1);
            cycle();
        end
        idle(0);
        idle(1);
        cycle();
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
